// File: rtl/intt_pkg.sv
// Shared constants for the inverse-NTT butterfly pipeline: default field parameters,
// mode encoding and the elaboration-time Barrett constant.
package intt_pkg;

  localparam int          DEF_DATA_WIDTH = 30;
  localparam int          DEF_LANES      = 2;
  localparam int unsigned DEF_MODULUS    = 32'd998244353;
  localparam int          DEF_TAG_WIDTH  = 18;
  localparam int          MU_MAX_W       = 128;

  typedef enum logic [1:0] {
    MODE_BFLY       = 2'b00,
    MODE_HALVE      = 2'b01,
    MODE_BYPASS     = 2'b10,
    MODE_BYPASS_ALT = 2'b11
  } mode_e;

  // mu = floor(2^(2*dw) / q); only ever evaluated as a constant function.
  function automatic logic [MU_MAX_W-1:0] barrett_mu(input int dw, input int unsigned q);
    logic [MU_MAX_W-1:0] num;
    num         = '0;
    num[2*dw]   = 1'b1;
    return num / {{(MU_MAX_W-32){1'b0}}, q};
  endfunction

endpackage

// File: rtl/mod_mult_barrett.sv
// Barrett modular multiplier covering S2 (product) and S3 (quotient estimate); the S4
// correction is combinational so the caller can halve before its output register.
module mod_mult_barrett
  import intt_pkg::*;
#(
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MODULUS    = DEF_MODULUS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_r
);

  localparam int                  DW      = DATA_WIDTH;
  localparam logic [MU_MAX_W-1:0] MU_FULL = barrett_mu(DW, MODULUS);
  localparam logic [4*DW-1:0]     MU      = MU_FULL[4*DW-1:0];
  localparam logic [DW+1:0]       Q2      = (DW+2)'(MODULUS);

  logic [2*DW-1:0] w_a_ext;
  logic [2*DW-1:0] w_b_ext;
  logic [4*DW-1:0] w_p_ext;
  logic [DW-1:0]   w_qhat;
  logic [DW+1:0]   w_t0;
  logic [DW+1:0]   w_t1;
  logic [DW+1:0]   w_t2;
  logic [2*DW-1:0] r_p2;
  logic [2*DW-1:0] r_p3;
  logic [DW-1:0]   r_qhat;

  assign w_a_ext = {{DW{1'b0}}, i_a};
  assign w_b_ext = {{DW{1'b0}}, i_b};
  assign w_p_ext = {{(2*DW){1'b0}}, r_p2};
  assign w_qhat  = DW'((w_p_ext * MU) >> (2*DW));

  // Product and quotient-estimate registers, frozen together with the rest of the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p2   <= '0;
      r_p3   <= '0;
      r_qhat <= '0;
    end else if (i_en) begin
      r_p2   <= w_a_ext * w_b_ext;
      r_p3   <= r_p2;
      r_qhat <= w_qhat;
    end
  end

  // The estimate undershoots by at most 2, so the remainder is below 3q and only the
  // low DW+2 bits of p - qhat*q matter.
  assign w_t0 = (DW+2)'(r_p3) - ((DW+2)'(r_qhat) * Q2);

  always_comb begin
    if (w_t0 >= Q2) w_t1 = w_t0 - Q2;
    else            w_t1 = w_t0;
    if (w_t1 >= Q2) w_t2 = w_t1 - Q2;
    else            w_t2 = w_t1;
  end

  assign o_r = DW'(w_t2);

endmodule

// File: rtl/intt_bfly_pipe.sv
// Inverse-NTT butterfly pipeline: LANES Gentleman-Sande butterflies per beat with optional
// halving or bypass, four register stages, whole-pipeline stall on output backpressure.
module intt_bfly_pipe
  import intt_pkg::*;
#(
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int          LANES      = DEF_LANES,
  parameter int unsigned MODULUS    = DEF_MODULUS,
  parameter int          TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [LANES*DATA_WIDTH-1:0] b_in,
  input  logic [LANES*DATA_WIDTH-1:0] w_in,
  input  logic [TAG_WIDTH-1:0]        tag_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] x_out,
  output logic [LANES*DATA_WIDTH-1:0] y_out,
  output logic [TAG_WIDTH-1:0]        tag_out
);

  localparam int            DW = DATA_WIDTH;
  localparam int            LW = LANES * DATA_WIDTH;
  localparam logic [DW:0]   Q1 = (DW+1)'(MODULUS);

  logic                 w_en;
  logic                 r_s1_v;
  logic                 r_s2_v;
  logic                 r_s3_v;
  mode_e                r_s1_mode;
  mode_e                r_s2_mode;
  mode_e                r_s3_mode;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic [TAG_WIDTH-1:0] r_s3_tag;
  logic [LW-1:0]        r_s1_x;
  logic [LW-1:0]        r_s2_x;
  logic [LW-1:0]        r_s3_x;
  logic [LW-1:0]        r_s1_d;
  logic [LW-1:0]        r_s2_d;
  logic [LW-1:0]        r_s3_d;
  logic [LW-1:0]        r_s1_w;
  logic [LW-1:0]        w_s1_x;
  logic [LW-1:0]        w_s1_d;
  logic [LW-1:0]        w_s4_x;
  logic [LW-1:0]        w_s4_y;

  // Exact division by two in the field: odd values borrow one q first.
  function automatic logic [DW-1:0] halve(input logic [DW-1:0] v);
    logic [DW:0] t;
    if (v[0]) t = {1'b0, v} + Q1;
    else      t = {1'b0, v};
    return DW'(t >> 1);
  endfunction

  assign w_en     = out_ready || !out_valid;
  assign in_ready = w_en;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_dif;
    logic [DW-1:0] w_x1;
    logic [DW-1:0] w_d1;
    logic [DW-1:0] w_x3;
    logic [DW-1:0] w_d3;
    logic [DW-1:0] w_prod;
    logic [DW-1:0] w_x4;
    logic [DW-1:0] w_y4;

    assign w_a   = a_in[l*DW +: DW];
    assign w_b   = b_in[l*DW +: DW];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif = {1'b0, w_a} - {1'b0, w_b};

    // S1: modular add/sub; a negative difference shows up as the borrow bit.
    always_comb begin
      if (mode[1]) begin
        w_x1 = w_a;
        w_d1 = w_b;
      end else begin
        if (w_sum >= Q1) w_x1 = DW'(w_sum - Q1);
        else             w_x1 = DW'(w_sum);
        if (w_dif[DW])   w_d1 = DW'(w_dif + Q1);
        else             w_d1 = DW'(w_dif);
      end
    end

    assign w_s1_x[l*DW +: DW] = w_x1;
    assign w_s1_d[l*DW +: DW] = w_d1;

    mod_mult_barrett #(
      .DATA_WIDTH (DW),
      .MODULUS    (MODULUS)
    ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_a   (r_s1_d[l*DW +: DW]),
      .i_b   (r_s1_w[l*DW +: DW]),
      .o_r   (w_prod)
    );

    assign w_x3 = r_s3_x[l*DW +: DW];
    assign w_d3 = r_s3_d[l*DW +: DW];

    // S4: select final result per mode; bypass returns the untouched b operand.
    always_comb begin
      case (r_s3_mode)
        MODE_BFLY: begin
          w_x4 = w_x3;
          w_y4 = w_prod;
        end
        MODE_HALVE: begin
          w_x4 = halve(w_x3);
          w_y4 = halve(w_prod);
        end
        default: begin
          w_x4 = w_x3;
          w_y4 = w_d3;
        end
      endcase
    end

    assign w_s4_x[l*DW +: DW] = w_x4;
    assign w_s4_y[l*DW +: DW] = w_y4;
  end

  // Stage and output registers advance as one; a stall freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_mode <= MODE_BFLY;
      r_s2_mode <= MODE_BFLY;
      r_s3_mode <= MODE_BFLY;
      r_s1_tag  <= '0;
      r_s2_tag  <= '0;
      r_s3_tag  <= '0;
      r_s1_x    <= '0;
      r_s2_x    <= '0;
      r_s3_x    <= '0;
      r_s1_d    <= '0;
      r_s2_d    <= '0;
      r_s3_d    <= '0;
      r_s1_w    <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      tag_out   <= '0;
    end else if (w_en) begin
      r_s1_v    <= in_valid;
      r_s2_v    <= r_s1_v;
      r_s3_v    <= r_s2_v;
      r_s1_mode <= mode_e'(mode);
      r_s2_mode <= r_s1_mode;
      r_s3_mode <= r_s2_mode;
      r_s1_tag  <= tag_in;
      r_s2_tag  <= r_s1_tag;
      r_s3_tag  <= r_s2_tag;
      r_s1_x    <= w_s1_x;
      r_s2_x    <= r_s1_x;
      r_s3_x    <= r_s2_x;
      r_s1_d    <= w_s1_d;
      r_s2_d    <= r_s1_d;
      r_s3_d    <= r_s2_d;
      r_s1_w    <= w_in;
      out_valid <= r_s3_v;
      x_out     <= w_s4_x;
      y_out     <= w_s4_y;
      tag_out   <= r_s3_tag;
    end
  end

endmodule
